picorv32_trace_buf: RTL and testbench

- Sits directly downstream of the picorv32 core's trace port in the simulation wrapper and captures every trace_valid/trace_data beat into a FIFO.
- A monitor or dump task drains the FIFO through a valid/ready port.
- The core cannot be back-pressured: a full FIFO drops beats and counts them.
- After a trap, the block captures a fixed number of post-trap beats and then freezes, so the tail of the execution history is preserved for debug.

---
 rtl/picorv32_trace_buf.sv | 122 ++++++++++++
 tb/tb_picorv32_trace_buf.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_trace_buf.sv
// Trace capture buffer for the picorv32 trace port: a first-word fall-through FIFO
// with drop/beat counters, a checksum, and a post-trap freeze so the tail of execution is kept.
module picorv32_trace_buf #(
  parameter int DEPTH     = 16,
  parameter int DW        = 36,
  parameter int CNT_W     = 32,
  parameter int POST_TRAP = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   trap,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [31:0]            csum,
  output logic                   frozen
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (POST_TRAP > 0) ? $clog2(POST_TRAP + 1) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_POST, ST_FROZEN} state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          capture;
  logic          pop;
  logic          push;
  logic          drop;

  assign capture   = en && in_valid && (state != ST_FROZEN);
  assign pop       = out_valid && out_ready;
  assign push      = capture && (!full || pop);
  assign drop      = capture && full && !pop;
  assign out_valid = (level != '0);
  assign empty     = (level == '0);
  assign full      = (level == (AW + 1)'(DEPTH));
  assign out_data  = mem[rd_ptr];
  assign frozen    = (state == ST_FROZEN);

  // Storage has no reset; validity is tracked entirely by level and the pointers.
  always_ff @(posedge clk) begin
    if (resetn && !clear && push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      beat_cnt <= '0;
      drop_cnt <= '0;
      csum     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        csum   <= {csum[30:0], csum[31]} ^ in_data[31:0] ^ {28'b0, in_data[35:32]};
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
      if (capture && (beat_cnt != '1))
        beat_cnt <= beat_cnt + CNT_W'(1);
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // pcnt holds the number of post-trap captures still allowed before freezing.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      state <= ST_RUN;
      pcnt  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (trap) begin
            if (POST_TRAP == 0) begin
              state <= ST_FROZEN;
            end else begin
              state <= ST_POST;
              pcnt  <= PW'(POST_TRAP);
            end
          end
        end
        ST_POST: begin
          if (capture) begin
            if (pcnt == PW'(1)) begin
              state <= ST_FROZEN;
              pcnt  <= '0;
            end else begin
              pcnt <= pcnt - PW'(1);
            end
          end
        end
        ST_FROZEN: state <= ST_FROZEN;
        default: begin
          state <= ST_RUN;
          pcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_trace_buf.sv
// Bench for picorv32_trace_buf: directed scenarios plus random traffic checked
// against a queue-based model of the buffer's capture/drop/freeze rules.
module tb_picorv32_trace_buf;

  localparam int DEPTH = 16;
  localparam int POST  = 8;

  logic        clk = 1'b0;
  logic        resetn, en, clear, trap, in_valid, out_ready;
  logic [35:0] in_data;
  logic        out_valid, full, empty, frozen;
  logic [35:0] out_data;
  logic [4:0]  level;
  logic [31:0] beat_cnt, drop_cnt, csum;

  int tests  = 0;
  int failed = 0;

  logic [35:0] q[$];
  logic [31:0] m_beat, m_drop, m_csum;
  bit          m_post, m_frozen;
  int          m_left;

  always #5 clk = ~clk;

  picorv32_trace_buf #(.DEPTH(DEPTH), .DW(36), .CNT_W(32), .POST_TRAP(POST)) dut (
    .clk(clk), .resetn(resetn), .en(en), .clear(clear), .trap(trap),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .level(level), .full(full),
    .empty(empty), .beat_cnt(beat_cnt), .drop_cnt(drop_cnt), .csum(csum),
    .frozen(frozen)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_beat = 0; m_drop = 0; m_csum = 0;
    m_post = 0; m_frozen = 0; m_left = 0;
  endtask

  // Model update for one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit cap, pop, was_full;
    if (!resetn || clear) begin
      model_reset();
      return;
    end
    cap      = en && in_valid && !m_frozen;
    pop      = (q.size() > 0) && out_ready;
    was_full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (cap) begin
      if (was_full && !pop) begin
        if (m_drop != 32'hFFFF_FFFF) m_drop++;
      end else begin
        q.push_back(in_data);
        m_csum = {m_csum[30:0], m_csum[31]} ^ in_data[31:0] ^ {28'b0, in_data[35:32]};
      end
      if (m_beat != 32'hFFFF_FFFF) m_beat++;
    end
    if (m_post) begin
      if (cap) begin
        m_left--;
        if (m_left == 0) begin m_post = 0; m_frozen = 1; end
      end
    end else if (!m_frozen && trap) begin
      if (POST == 0) m_frozen = 1;
      else begin m_post = 1; m_left = POST; end
    end
  endtask

  task automatic check_all();
    chk("level", 64'(level), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
    chk("beat_cnt", 64'(beat_cnt), 64'(m_beat));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("csum", 64'(csum), 64'(m_csum));
    chk("frozen", 64'(frozen), 64'(m_frozen));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    resetn = 1; en = 1; clear = 0; trap = 0; in_valid = 0; out_ready = 0; in_data = '0;
  endtask

  task automatic do_clear();
    clear = 1; cyc(); clear = 0;
  endtask

  task automatic beats(input int n, input logic [35:0] base);
    in_valid = 1;
    for (int i = 0; i < n; i++) begin
      in_data = base + 36'(i);
      cyc();
    end
    in_valid = 0;
  endtask

  task automatic drain(input int n);
    out_ready = 1;
    for (int i = 0; i < n; i++) cyc();
    out_ready = 0;
  endtask

  initial begin
    idle();
    resetn = 0;
    cyc(); cyc();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    resetn = 1;

    // Five beats held back, then drained in order.
    beats(5, 36'h1_0000_0001);
    chk("five_level", 64'(level), 64'd5);
    drain(5);
    chk("five_drained", 64'(level), 64'd0);

    // Overfill a 16-deep FIFO with 20 beats.
    do_clear();
    beats(20, 36'h2_0000_0100);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_drop", 64'(drop_cnt), 64'd4);
    chk("ovf_beat", 64'(beat_cnt), 64'd20);

    // Push and pop together while full: no drop, level holds, new beat lands last.
    in_valid = 1; out_ready = 1; in_data = 36'hA_DEAD_BEEF;
    cyc();
    in_valid = 0; out_ready = 0;
    chk("pp_level", 64'(level), 64'd16);
    chk("pp_drop", 64'(drop_cnt), 64'd4);
    drain(15);
    chk("pp_last", 64'(out_data), 64'hA_DEAD_BEEF);
    drain(1);

    // Trap with a beat, then 12 more beats: only trap beat + POST are kept.
    do_clear();
    trap = 1; in_valid = 1; in_data = 36'h3_0000_0000;
    cyc();
    trap = 0;
    beats(12, 36'h3_0000_0001);
    chk("trap_level", 64'(level), 64'(POST + 1));
    chk("trap_beat", 64'(beat_cnt), 64'(POST + 1));
    chk("trap_frozen", 64'(frozen), 64'd1);
    drain(POST + 2);
    chk("trap_drained", 64'(empty), 64'd1);

    // Clear mid-operation with a beat presented in the same cycle.
    do_clear();
    beats(7, 36'h4_0000_0010);
    chk("pre_clr_level", 64'(level), 64'd7);
    clear = 1; in_valid = 1; in_data = 36'h4_FFFF_FFFF;
    cyc();
    clear = 0; in_valid = 0;
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_beat", 64'(beat_cnt), 64'd0);
    chk("clr_csum", 64'(csum), 64'd0);

    // Freeze, then reset; then ignore beats while disabled.
    trap = 1; cyc(); trap = 0;
    beats(POST, 36'h5_0000_0000);
    chk("frz_frozen", 64'(frozen), 64'd1);
    resetn = 0; cyc(); resetn = 1;
    chk("rst2_frozen", 64'(frozen), 64'd0);
    chk("rst2_level", 64'(level), 64'd0);
    en = 0;
    beats(10, 36'h6_0000_0000);
    chk("dis_beat", 64'(beat_cnt), 64'd0);
    chk("dis_level", 64'(level), 64'd0);
    en = 1;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      resetn    = ($urandom_range(0, 199) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      trap      = ($urandom_range(0, 39) == 0);
      en        = ($urandom_range(0, 7) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      in_data   = {4'($urandom), 32'($urandom)};
      cyc();
    end
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
